// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared fetch-side definitions for the RV32I core: reset PC and
//               NOP constants, fetch FSM state encoding, and the IF/ID bundle
//               also consumed by the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;
    // addi x0,x0,0
    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } ifid_t;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Bundle of the fetch-stage control, instruction-memory and
//               IF/ID signals. The slave modport is the fetch stage's view;
//               the master modport is the surrounding core (or bench).
//   Inputs to the stage : stall_i, redirect_valid_i, redirect_pc_i, halt_i,
//                         resume_i, instr_i
//   Outputs of the stage: pc_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o,
//                         ifid_instr_o, misalign_o, fetch_cnt_o, state_o
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        resume_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_instr_o;
    logic        misalign_o;
    logic [31:0] fetch_cnt_o;
    logic [1:0]  state_o;

    modport slave (
        input  stall_i, redirect_valid_i, redirect_pc_i, halt_i, resume_i, instr_i,
        output pc_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
               misalign_o, fetch_cnt_o, state_o
    );

    modport master (
        output stall_i, redirect_valid_i, redirect_pc_i, halt_i, resume_i, instr_i,
        input  pc_o, ifid_valid_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o,
               misalign_o, fetch_cnt_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : Pipeline latch with hold and flush controls. Flush loads a
//               bubble (valid=0, pc/pc4=0, NOP) and wins over hold; hold keeps
//               every field, valid included.
//   clk, rst (async, active-high), i_hold, i_flush, i_d -> o_q
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  i_hold,
    input  wire logic  i_flush,
    input  wire ifid_t i_d,
    output ifid_t      o_q
);

    localparam ifid_t C_BUBBLE = '{valid: 1'b0, pc: 32'h0, pc4: 32'h0, instr: NOP_INSTR};

    ifid_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= C_BUBBLE;
        end else if (i_flush) begin
            r_q <= C_BUBBLE;
        end else if (!i_hold) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : RV32I instruction-fetch front end. Owns the PC, drives it to
//               instruction memory, captures the returned word into the IF/ID
//               latch. Handles boot delay, stall, redirect/flush, halt/resume
//               and misaligned redirect targets.
//   CLK, RESET (async, active-high), bus (if_stage_if.slave)
//   BOOT_CYCLES legal range 1..15.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = C_RESET_PC,
    parameter int unsigned BOOT_CYCLES = 2,
    parameter logic [31:0] NOP_INSTR   = C_NOP_INSTR
) (
    input  wire logic  CLK,
    input  wire logic  RESET,
    if_stage_if.slave  bus
);

    localparam logic [3:0]  C_BOOT_LAST = 4'(BOOT_CYCLES - 1);
    // The fetch address is word aligned by construction.
    localparam logic [31:0] C_PC_INIT   = {RESET_PC[31:2], 2'b00};

    fetch_state_t r_state, w_state_nxt;
    logic [3:0]   r_boot_cnt, w_boot_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_misalign, w_misalign_nxt;
    logic [31:0]  r_fetch_cnt;
    logic         w_cnt_inc;
    logic         w_hold;
    logic         w_flush;
    logic [31:0]  w_pc4;
    logic         w_redir_ok;
    ifid_t        w_ifid_d;
    ifid_t        w_ifid_q;

    assign w_pc4      = r_pc + 32'd4;
    assign w_redir_ok = is_aligned(bus.redirect_pc_i);
    assign w_ifid_d   = '{valid: 1'b1, pc: r_pc, pc4: w_pc4, instr: bus.instr_i};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= 4'd0;
            r_pc        <= C_PC_INIT;
            r_misalign  <= 1'b0;
            r_fetch_cnt <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_boot_cnt  <= w_boot_nxt;
            r_pc        <= w_pc_nxt;
            r_misalign  <= w_misalign_nxt;
            r_fetch_cnt <= r_fetch_cnt + {31'd0, w_cnt_inc};
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_boot_nxt     = r_boot_cnt;
        w_pc_nxt       = r_pc;
        w_misalign_nxt = 1'b0;
        w_cnt_inc      = 1'b0;
        w_hold         = 1'b0;
        w_flush        = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_flush    = 1'b1;
                w_boot_nxt = r_boot_cnt + 4'd1;
                if (r_boot_cnt == C_BOOT_LAST) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.redirect_valid_i && w_redir_ok) begin
                    // Redirect beats stall and halt; a coincident halt parks
                    // at the new target so it is fetched on resume.
                    w_pc_nxt = {bus.redirect_pc_i[31:2], 2'b00};
                    w_flush  = 1'b1;
                    if (bus.halt_i) begin
                        w_state_nxt = ST_HALT;
                    end
                end else if (bus.redirect_valid_i) begin
                    w_flush        = 1'b1;
                    w_misalign_nxt = 1'b1;
                    w_state_nxt    = ST_HALT;
                end else if (bus.halt_i) begin
                    // Current pc is not consumed; it is refetched on resume.
                    w_flush     = 1'b1;
                    w_state_nxt = ST_HALT;
                end else if (bus.stall_i) begin
                    w_hold = 1'b1;
                end else begin
                    w_pc_nxt  = w_pc4;
                    w_cnt_inc = 1'b1;
                end
            end
            ST_HALT: begin
                w_flush = 1'b1;
                if (bus.redirect_valid_i) begin
                    if (w_redir_ok) begin
                        w_pc_nxt = {bus.redirect_pc_i[31:2], 2'b00};
                    end else begin
                        w_misalign_nxt = 1'b1;
                    end
                end
                if (bus.resume_i) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_flush     = 1'b1;
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (CLK),
        .rst     (RESET),
        .i_hold  (w_hold),
        .i_flush (w_flush),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign bus.pc_o         = r_pc;
    assign bus.ifid_valid_o = w_ifid_q.valid;
    assign bus.ifid_pc_o    = w_ifid_q.pc;
    assign bus.ifid_pc4_o   = w_ifid_q.pc4;
    assign bus.ifid_instr_o = w_ifid_q.instr;
    assign bus.misalign_o   = r_misalign;
    assign bus.fetch_cnt_o  = r_fetch_cnt;
    assign bus.state_o      = r_state;

endmodule
`default_nettype wire
